trace_capture_buffer: RTL and testbench
=======================================

Name: trace_capture_buffer

Overview:
Synthesizable on-chip successor to the per-cycle PC/instruction/regfile dump used in simulation of the single-cycle MIPS CPU.
- Sits beside the CPU core and snoops its commit signals: pc, inst, and the regfile write port.
- Stores selected commit records in a parametrised FIFO.
- Supports three capture modes: continuous, register-write-only, and PC-triggered window.
- Records drain through a valid/ready stream to a UART or debug reader.

Parameters:
DEPTH, 64, FIFO entries; power of two, at least 4.
PC_W, 32, PC width.
DATA_W, 32, instruction and writeback data width.
REG_AW, 5, regfile address width.
CNT_W, 16, width of the drop counter.

Ports:
clk_in  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
en  in  1  capture enable.
mode  in  2  capture mode: 0 = continuous, 1 = write-only, 2 = triggered, 3 = reserved (treated as 0).
trig_pc  in  PC_W  trigger PC for mode 2.
post_count  in  $clog2(DEPTH)+1  number of records kept after the trigger record in mode 2.
cpu_valid  in  1  CPU retired an instruction this cycle.
pc  in  PC_W  PC of the retiring instruction.
inst  in  DATA_W  retiring instruction word.
rf_we  in  1  regfile write enable.
rf_waddr  in  REG_AW  regfile write address.
rf_wdata  in  DATA_W  regfile write data.
out_valid  out  1  head record available.
out_ready  in  1  consumer accepts the head record.
out_pc  out  PC_W  head record PC field.
out_inst  out  DATA_W  head record instruction field.
out_we  out  1  head record write-enable field.
out_waddr  out  REG_AW  head record write-address field.
out_wdata  out  DATA_W  head record write-data field.
level  out  $clog2(DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky: at least one qualifying record was dropped.
drop_cnt  out  CNT_W  count of dropped records; saturates.
state  out  2  FSM state.
done  out  1  high while the FSM is in DONE.

Behaviour:
- Reset (synchronous): state=IDLE, FIFO empty, level=0, out_valid=0, overflow=0, drop_cnt=0, done=0.
  - out_* data fields are don't-care while out_valid=0.
- A reset asserted mid-capture discards all stored records.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - IDLE -> CAPTURE when en=1 and the latched mode is 0 or 1.
  - IDLE -> ARMED when en=1 and the latched mode is 2.
  - mode, trig_pc and post_count are latched on leaving IDLE; later changes have no effect until the FSM returns to IDLE.
  - ARMED -> CAPTURE when cpu_valid and pc==trig_pc. The trigger record itself is captured in that same cycle.
  - CAPTURE (mode 2): counts captured records after the trigger. When that count equals the latched post_count, the FSM goes to DONE on the same edge that writes the last record.
    - post_count=0: the trigger record is the only record; the FSM goes ARMED -> DONE directly.
  - CAPTURE (mode 0/1) -> IDLE when en=0.
  - ARMED or CAPTURE -> IDLE when en=0 in any mode. FIFO contents are retained.
  - DONE -> IDLE when en=0.
- Qualifying record, only when state=CAPTURE (or the ARMED trigger cycle):
  - mode 0: cpu_valid=1.
  - mode 1: cpu_valid=1, rf_we=1, rf_waddr!=0.
  - mode 2: cpu_valid=1.
- Record format: {pc, inst, rf_we, rf_waddr, rf_wdata}. Written at the clock edge of the qualifying cycle.
- Readout: out_valid = (level!=0). out_* show the head record combinationally from storage.
  - out_valid and out_* are visible the cycle after the write (1-cycle capture-to-visible latency).
  - A pop occurs when out_valid && out_ready. out_* stay stable while out_valid=1 and out_ready=0.
  - Readout operates in every state, including IDLE and DONE.
- Full FIFO: a qualifying record is accepted only if level<DEPTH, or if a pop occurs in the same cycle (simultaneous push and pop at full is accepted; level unchanged).
  - Otherwise the record is dropped: overflow becomes 1 (sticky until reset) and drop_cnt increments, saturating at all-ones.
  - In mode 2, dropped records still count toward post_count.
- Pointers: $clog2(DEPTH) bits each, wrapping modulo DEPTH. level is updated +1, -1 or 0 in the same edge as the push/pop.
- Empty FIFO with push and out_ready in the same cycle: no pop occurs (out_valid=0); level becomes 1.

Decomposition:
- Package trace_pkg:
  - state encodings ST_IDLE/ST_ARMED/ST_CAPTURE/ST_DONE;
  - mode constants MODE_CONT/MODE_WR/MODE_TRIG;
  - function computing record width PC_W+2*DATA_W+1+REG_AW.
- Sub-module trace_fifo:
  - synchronous FIFO parametrised by width and depth;
  - push/pop/full/empty/level interface.
- Top level holds the FSM, qualification logic, the post-trigger counter and the drop counter.

Test Plan:
- Mode 0: en=1, 5 consecutive cpu_valid cycles with pc=0x00400000+4k -> level=5; draining with out_ready=1 returns pc 0x00400000..0x00400010 in order, then out_valid=0.
- Mode 1: 6 retires, rf_we on 3 of them (one with rf_waddr=0) -> exactly 2 records captured, with correct waddr/wdata.
- Mode 2: trig_pc=0x00400020, post_count=3, pc stepping by 4 from 0x00400000 -> 4 records (0x00400020..0x0040002C); done=1 after the 4th write; state=3; later retires are ignored.
- Overflow, DEPTH=4, out_ready=0: 7 qualifying retires -> level=4, overflow=1, drop_cnt=3. Then one cycle with push and pop both active -> level stays 4, drop_cnt stays 3.
- Backpressure: toggle out_ready randomly -> out_* stable whenever out_valid && !out_ready; no record lost or duplicated.
- Reset mid-CAPTURE with level=3 -> next cycle state=0, level=0, out_valid=0, overflow=0, drop_cnt=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared encodings and record-width helper for the commit trace capture buffer.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [1:0] MODE_CONT = 2'd0;
    localparam logic [1:0] MODE_WR   = 2'd1;
    localparam logic [1:0] MODE_TRIG = 2'd2;

    // One stored record is {pc, inst, rf_we, rf_waddr, rf_wdata}.
    function automatic int rec_width(input int pc_w, input int data_w, input int reg_aw);
        return pc_w + 2 * data_w + 1 + reg_aw;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO; the head entry is presented combinationally from storage.
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    // DEPTH is a power of two, so the level MSB alone marks a full FIFO.
    assign full_o  = level_q[AW];
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/trace_capture_buffer.sv
// Snoops CPU commit signals, filters them by capture mode and queues the
// selected records for a downstream reader.
module trace_capture_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [PC_W-1:0]        trig_pc,
    input  logic [$clog2(DEPTH):0] post_count,
    input  logic                   cpu_valid,
    input  logic [PC_W-1:0]        pc,
    input  logic [DATA_W-1:0]      inst,
    input  logic                   rf_we,
    input  logic [REG_AW-1:0]      rf_waddr,
    input  logic [DATA_W-1:0]      rf_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [DATA_W-1:0]      out_inst,
    output logic                   out_we,
    output logic [REG_AW-1:0]      out_waddr,
    output logic [DATA_W-1:0]      out_wdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [1:0]             state,
    output logic                   done
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int RW = rec_width(PC_W, DATA_W, REG_AW);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [PC_W-1:0]   trig_q, trig_d;
    logic [LW-1:0]     post_q, post_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              overflow_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [1:0]        mode_eff;
    logic              qual;
    logic              pop;
    logic              push_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [RW-1:0]     rec_wdata;
    logic [RW-1:0]     rec_rdata;

    // Stream handshake: a record transfers on a cycle where out_valid && out_ready;
    // the head record and out_valid never change while out_valid && !out_ready.
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push_ok   = qual && (!fifo_full || pop);
    assign mode_eff  = (mode == 2'd3) ? MODE_CONT : mode;
    assign rec_wdata = {pc, inst, rf_we, rf_waddr, rf_wdata};
    assign {out_pc, out_inst, out_we, out_waddr, out_wdata} = rec_rdata;
    assign state     = state_q;
    assign done      = (state_q == ST_DONE);
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        trig_d  = trig_q;
        post_d  = post_q;
        cnt_d   = cnt_q;
        qual    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    mode_d  = mode_eff;
                    trig_d  = trig_pc;
                    post_d  = post_count;
                    cnt_d   = '0;
                    state_d = (mode_eff == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (cpu_valid && (pc == trig_q)) begin
                    qual    = 1'b1;
                    cnt_d   = '0;
                    state_d = (post_q == '0) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    case (mode_q)
                        MODE_WR:   qual = cpu_valid && rf_we && (rf_waddr != '0);
                        MODE_TRIG: begin
                            // Dropped records still advance the post-trigger count.
                            if (cpu_valid) begin
                                qual  = 1'b1;
                                cnt_d = cnt_q + LW'(1);
                                if (cnt_d == post_q) state_d = ST_DONE;
                            end
                        end
                        default:   qual = cpu_valid;
                    endcase
                end
            end
            ST_DONE: begin
                if (!en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_CONT;
            trig_q     <= '0;
            post_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            trig_q  <= trig_d;
            post_q  <= post_d;
            cnt_q   <= cnt_d;
            if (qual && !push_ok) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    trace_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (reset),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i (rec_wdata),
        .rdata_o (rec_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: a DEPTH=64 instance for the capture
// modes and a DEPTH=4 instance sharing its inputs for the overflow scenarios.
module tb_trace_capture_buffer;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] trig_pc = '0;
    logic [6:0]  post_count = '0;
    logic        cpu_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic [31:0] rf_wdata = '0;
    logic        out_ready = 1'b0;
    logic        ready4 = 1'b0;

    logic        out_valid, out_we, overflow, done;
    logic [31:0] out_pc, out_inst, out_wdata;
    logic [4:0]  out_waddr;
    logic [6:0]  level;
    logic [15:0] drop_cnt;
    logic [1:0]  state;

    logic        out_valid4, out_we4, overflow4, done4;
    logic [31:0] out_pc4, out_inst4, out_wdata4;
    logic [4:0]  out_waddr4;
    logic [2:0]  level4;
    logic [15:0] drop_cnt4;
    logic [1:0]  state4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    trace_capture_buffer dut (
        .clk_in(clk_in), .reset(reset), .en(en), .mode(mode), .trig_pc(trig_pc),
        .post_count(post_count), .cpu_valid(cpu_valid), .pc(pc), .inst(inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_we(out_we), .out_waddr(out_waddr),
        .out_wdata(out_wdata), .level(level), .overflow(overflow),
        .drop_cnt(drop_cnt), .state(state), .done(done)
    );

    trace_capture_buffer #(.DEPTH(4)) dut4 (
        .clk_in(clk_in), .reset(reset), .en(en), .mode(mode), .trig_pc(trig_pc),
        .post_count(post_count[2:0]), .cpu_valid(cpu_valid), .pc(pc), .inst(inst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .out_valid(out_valid4), .out_ready(ready4), .out_pc(out_pc4),
        .out_inst(out_inst4), .out_we(out_we4), .out_waddr(out_waddr4),
        .out_wdata(out_wdata4), .level(level4), .overflow(overflow4),
        .drop_cnt(drop_cnt4), .state(state4), .done(done4)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got ovf=%b cnt=%0d expected 0/0", overflow, drop_cnt); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_mode_cont();
        mode = 2'd0; en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            cpu_valid = 1'b1; pc = 32'h0040_0000 + 32'(4 * k); inst = 32'h1000 + 32'(k);
            tick();
        end
        cpu_valid = 1'b0;
        n_checks++; if (level !== 7'd5) begin n_fail++; $display("FAIL cont_level: got %0d expected 5", level); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL cont_state: got %0d expected 2", state); end
        en = 1'b0;
        tick();
        n_checks++; if (state !== 2'd0 || level !== 7'd5) begin n_fail++; $display("FAIL cont_disable: got state=%0d level=%0d expected 0/5", state, level); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000 + 32'(4 * k) || out_inst !== 32'h1000 + 32'(k)) begin
                n_fail++;
                $display("FAIL cont_drain%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, out_valid, out_pc, out_inst, 32'h0040_0000 + 32'(4 * k), 32'h1000 + 32'(k));
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || level !== 7'd0) begin n_fail++; $display("FAIL cont_empty: got v=%b level=%0d expected 0/0", out_valid, level); end
    endtask

    task automatic test_mode_wr();
        logic        we_v [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0]  wa_v [6]  = '{5'd3, 5'd5, 5'd7, 5'd0, 5'd9, 5'd2};
        logic [31:0] wd_v [6]  = '{32'h11, 32'hAAAA_0005, 32'h33, 32'hDEAD_BEEF, 32'h1234_5678, 32'h66};
        logic [31:0] exp_pc [2] = '{32'h0040_0104, 32'h0040_0110};
        logic [4:0]  exp_wa [2] = '{5'd5, 5'd9};
        logic [31:0] exp_wd [2] = '{32'hAAAA_0005, 32'h1234_5678};
        mode = 2'd1; en = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            cpu_valid = 1'b1; pc = 32'h0040_0100 + 32'(4 * k); inst = 32'h2000 + 32'(k);
            rf_we = we_v[k]; rf_waddr = wa_v[k]; rf_wdata = wd_v[k];
            tick();
        end
        cpu_valid = 1'b0; rf_we = 1'b0; en = 1'b0;
        tick();
        n_checks++; if (level !== 7'd2) begin n_fail++; $display("FAIL wr_level: got %0d expected 2", level); end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[k] || out_we !== 1'b1 || out_waddr !== exp_wa[k] || out_wdata !== exp_wd[k]) begin
                n_fail++;
                $display("FAIL wr_rec%0d: got v=%b pc=%h we=%b wa=%0d wd=%h expected v=1 pc=%h we=1 wa=%0d wd=%h", k, out_valid, out_pc, out_we, out_waddr, out_wdata, exp_pc[k], exp_wa[k], exp_wd[k]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wr_empty: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_mode_trig();
        mode = 2'd2; trig_pc = 32'h0040_0020; post_count = 7'd3; en = 1'b1;
        tick();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL trig_armed: got %0d expected 1", state); end
        mode = 2'd0; trig_pc = 32'h0; post_count = 7'd0;
        for (int k = 0; k < 16; k++) begin
            cpu_valid = 1'b1; pc = 32'h0040_0000 + 32'(4 * k); inst = 32'h3000 + 32'(k);
            tick();
            if (k == 8) begin
                n_checks++; if (state !== 2'd2 || done !== 1'b0) begin n_fail++; $display("FAIL trig_hit: got state=%0d done=%b expected 2/0", state, done); end
            end
            if (k == 11) begin
                n_checks++; if (state !== 2'd3 || done !== 1'b1) begin n_fail++; $display("FAIL trig_done: got state=%0d done=%b expected 3/1", state, done); end
            end
        end
        cpu_valid = 1'b0;
        n_checks++; if (level !== 7'd4 || state !== 2'd3) begin n_fail++; $display("FAIL trig_level: got level=%0d state=%0d expected 4/3", level, state); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0040_0020 + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL trig_rec%0d: got v=%b pc=%h expected v=1 pc=%h", k, out_valid, out_pc, 32'h0040_0020 + 32'(4 * k));
            end
            tick();
        end
        out_ready = 1'b0; en = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL trig_empty: got v=%b expected 0", out_valid); end
        tick();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL trig_idle: got %0d expected 0", state); end
    endtask

    task automatic test_overflow();
        pulse_reset();
        mode = 2'd0; en = 1'b1; ready4 = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            cpu_valid = 1'b1; pc = 32'h0050_0000 + 32'(4 * k);
            tick();
        end
        n_checks++; if (level4 !== 3'd4 || overflow4 !== 1'b1 || drop_cnt4 !== 16'd3) begin n_fail++; $display("FAIL ovf_full: got level=%0d ovf=%b cnt=%0d expected 4/1/3", level4, overflow4, drop_cnt4); end
        n_checks++; if (out_pc4 !== 32'h0050_0000) begin n_fail++; $display("FAIL ovf_head: got %h expected 00500000", out_pc4); end
        ready4 = 1'b1; pc = 32'h0050_0100;
        tick();
        ready4 = 1'b0; cpu_valid = 1'b0;
        n_checks++; if (level4 !== 3'd4 || drop_cnt4 !== 16'd3) begin n_fail++; $display("FAIL ovf_pushpop: got level=%0d cnt=%0d expected 4/3", level4, drop_cnt4); end
        n_checks++; if (out_pc4 !== 32'h0050_0004) begin n_fail++; $display("FAIL ovf_newhead: got %h expected 00500004", out_pc4); end
        en = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        int seq = 0;
        pulse_reset();
        mode = 2'd0; en = 1'b1;
        tick();
        for (int c = 0; c < 80; c++) begin
            cpu_valid = (c < 50) ? 1'($urandom_range(0, 1)) : 1'b0;
            pc = 32'h0060_0000 + 32'(4 * seq);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0 || out_pc !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL bp_head%0d: got pc=%h expected %h (queue size %0d)", c, out_pc, (exp_q.size() != 0) ? exp_q[0] : 32'h0, exp_q.size());
                end
                if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (cpu_valid) begin
                exp_q.push_back(pc);
                seq++;
            end
            tick();
        end
        cpu_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_q[0]) begin
                n_fail++;
                $display("FAIL bp_drain: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_final: got pending=%0d v=%b expected 0/0", exp_q.size(), out_valid); end
        en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        mode = 2'd0; en = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            cpu_valid = 1'b1; pc = 32'h0070_0000 + 32'(4 * k);
            tick();
        end
        cpu_valid = 1'b0;
        n_checks++; if (level !== 7'd3 || state !== 2'd2) begin n_fail++; $display("FAIL mid_pre: got level=%0d state=%0d expected 3/2", level, state); end
        pulse_reset();
        n_checks++; if (state !== 2'd0 || level !== 7'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got state=%0d level=%0d v=%b expected 0/0/0", state, level, out_valid); end
        n_checks++; if (overflow4 !== 1'b0 || drop_cnt4 !== 16'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_drop: got ovf4=%b cnt4=%0d ovf=%b cnt=%0d expected all 0", overflow4, drop_cnt4, overflow, drop_cnt); end
        en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_mode_cont();
        test_mode_wr();
        test_mode_trig();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
